// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: core state encoding,
// decoded instruction flags and the stage FSM states.
package mem_access_pkg;

  // Core controller state in which the memory-access stage runs.
  localparam logic [2:0] MEM = 3'd3;

  typedef struct packed {
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } instructions;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  function automatic logic is_load(input instructions i);
    return i.lb | i.lh | i.lw | i.lbu | i.lhu;
  endfunction

  function automatic logic is_store(input instructions i);
    return i.sb | i.sh | i.sw;
  endfunction

  function automatic logic is_misaligned(input instructions i, input logic [1:0] lane);
    return ((i.lw | i.sw) & (lane != 2'b00)) |
           ((i.lh | i.lhu | i.sh) & lane[0]);
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Selects the addressed byte/half/word from a bus read word and
// sign- or zero-extends it to 32 bits.
module mem_access_load_extend (
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic        lb,
  input  logic        lh,
  input  logic        lw,
  input  logic        lbu,
  input  logic        lhu,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*lane +: 8];
  assign half_sel = rdata[16*lane[1] +: 16];

  always_comb begin
    value = '0;
    if (lb)       value = {{24{byte_sel[7]}}, byte_sel};
    else if (lbu) value = {24'd0, byte_sel};
    else if (lh)  value = {{16{half_sel[15]}}, half_sel};
    else if (lhu) value = {16'd0, half_sel};
    else if (lw)  value = rdata;
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: performs one load/store on the req/ready bus per
// MEM visit and hands the writeback value to the next stage.
//
//  state | meaning
//  IDLE  | waiting for state == MEM; captures inputs and classifies access
//  REQ   | bus request held until mem_ready or timeout
//  DONE  | done high; waits for the controller to leave MEM
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  state,
  input  instructions instr,
  input  logic [31:0] mem_target,
  input  logic [31:0] store_value,
  input  logic [31:0] result_in,
  input  logic        reg_write_enabled_in,
  input  logic [4:0]  reg_write_dest_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] result,
  output logic        reg_write_enabled,
  output logic [4:0]  reg_write_dest,
  output logic        done,
  output logic        misaligned,
  output logic        bus_error
);

  mem_state_t  st, st_nxt;

  instructions cap_instr;
  logic [31:0] cap_addr;
  logic [31:0] cap_value;
  logic        cap_we;
  logic [4:0]  cap_dest;
  logic [31:0] tcnt;

  logic        active;
  logic        in_load, in_store, in_mis;
  logic        cap_store;
  logic        timeout_hit;
  logic [31:0] load_value;
  logic [31:0] steer_wdata;
  logic [3:0]  steer_wstrb;

  assign active      = (state == MEM);
  assign in_load     = is_load(instr);
  assign in_store    = is_store(instr);
  assign in_mis      = is_misaligned(instr, mem_target[1:0]);
  assign cap_store   = is_store(cap_instr);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));

  mem_access_load_extend u_load_extend (
    .rdata (mem_rdata),
    .lane  (cap_addr[1:0]),
    .lb    (cap_instr.lb),
    .lh    (cap_instr.lh),
    .lw    (cap_instr.lw),
    .lbu   (cap_instr.lbu),
    .lhu   (cap_instr.lhu),
    .value (load_value)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (active) begin
          if (in_mis || !(in_load || in_store)) st_nxt = DONE;
          else                                  st_nxt = REQ;
        end
      end
      // A request is only ever withdrawn by timeout, even if MEM is left.
      REQ:     if (mem_ready || timeout_hit) st_nxt = DONE;
      DONE:    if (!active) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    steer_wdata = cap_value;
    steer_wstrb = 4'b1111;
    if (cap_instr.sb) begin
      steer_wdata = {4{cap_value[7:0]}};
      steer_wstrb = 4'b0001 << cap_addr[1:0];
    end else if (cap_instr.sh) begin
      steer_wdata = {2{cap_value[15:0]}};
      steer_wstrb = 4'b0011 << cap_addr[1:0];
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    done      = 1'b0;
    case (st)
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = cap_store;
        mem_addr  = {cap_addr[31:2], 2'b00};
        mem_wdata = cap_store ? steer_wdata : '0;
        mem_wstrb = cap_store ? steer_wstrb : 4'b0000;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_instr         <= '0;
      cap_addr          <= '0;
      cap_value         <= '0;
      cap_we            <= 1'b0;
      cap_dest          <= '0;
      tcnt              <= '0;
      result            <= '0;
      reg_write_enabled <= 1'b0;
      misaligned        <= 1'b0;
      bus_error         <= 1'b0;
    end else begin
      reg_write_enabled <= 1'b0;
      case (st)
        IDLE: begin
          if (active) begin
            cap_instr  <= instr;
            cap_addr   <= mem_target;
            cap_value  <= store_value;
            cap_we     <= reg_write_enabled_in;
            cap_dest   <= reg_write_dest_in;
            tcnt       <= '0;
            result     <= result_in;
            misaligned <= in_mis;
            bus_error  <= 1'b0;
            // Only pass-through ops complete here; faults never write back.
            reg_write_enabled <= reg_write_enabled_in && !(in_load || in_store);
          end
        end
        REQ: begin
          tcnt <= tcnt + 32'd1;
          if (mem_ready) begin
            if (is_load(cap_instr)) result <= load_value;
            reg_write_enabled <= cap_we && !cap_store;
          end else if (timeout_hit) begin
            bus_error <= 1'b1;
          end
        end
        DONE: begin
          if (!active) begin
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_write_dest = cap_dest;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a per-transaction timeline model predicts
// every output for each cycle, checked by one compare process at negedge.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int T = 4;

  typedef enum {OP_ADD, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW} op_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  state;
  instructions instr;
  logic [31:0] mem_target, store_value, result_in;
  logic        reg_write_enabled_in;
  logic [4:0]  reg_write_dest_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] result;
  logic        reg_write_enabled;
  logic [4:0]  reg_write_dest;
  logic        done, misaligned, bus_error;

  int total = 0;
  int bad   = 0;

  // current transaction descriptor (k = clock edges since state became MEM)
  int          k = 0;
  logic        txn_active = 1'b0;
  logic        quiet = 1'b0;
  int          cur_R, cur_Le;
  logic        cur_wb, cur_st, cur_mis, cur_to, cur_chk_res, cur_has_lit;
  logic [31:0] cur_addr_w, cur_wdata, cur_res, cur_lit;
  logic [3:0]  cur_wstrb;
  logic [4:0]  cur_rd;

  mem_access #(.TIMEOUT_CYCLES(T)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .state                (state),
    .instr                (instr),
    .mem_target           (mem_target),
    .store_value          (store_value),
    .result_in            (result_in),
    .reg_write_enabled_in (reg_write_enabled_in),
    .reg_write_dest_in    (reg_write_dest_in),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_wstrb            (mem_wstrb),
    .mem_ready            (mem_ready),
    .mem_rdata            (mem_rdata),
    .result               (result),
    .reg_write_enabled    (reg_write_enabled),
    .reg_write_dest       (reg_write_dest),
    .done                 (done),
    .misaligned           (misaligned),
    .bus_error            (bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s (k=%0d): got %h expected %h", nm, k, act, exp_v);
    end
  endtask

  function automatic instructions to_instr(input op_t op);
    instructions i;
    i = '0;
    case (op)
      OP_LB:   i.lb  = 1'b1;
      OP_LH:   i.lh  = 1'b1;
      OP_LW:   i.lw  = 1'b1;
      OP_LBU:  i.lbu = 1'b1;
      OP_LHU:  i.lhu = 1'b1;
      OP_SB:   i.sb  = 1'b1;
      OP_SH:   i.sh  = 1'b1;
      OP_SW:   i.sw  = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

  function automatic int op_size(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic op_store(input op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [31:0] m_load(input op_t op, input logic [31:0] addr, input logic [31:0] rd_word);
    logic [31:0] w;
    int sz;
    sz = op_size(op);
    w = rd_word >> (8 * int'(addr[1:0]));
    if (sz == 1) begin
      w = w & 32'h0000_00FF;
      if (op == OP_LB && w[7]) w = w | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      w = w & 32'h0000_FFFF;
      if (op == OP_LH && w[15]) w = w | 32'hFFFF_0000;
    end
    return w;
  endfunction

  function automatic logic [3:0] m_strb(input op_t op, input logic [31:0] addr);
    logic [3:0] s;
    int lane, sz;
    s = '0;
    lane = int'(addr[1:0]);
    sz = op_size(op);
    for (int i = 0; i < 4; i++)
      if (op_store(op) && i >= lane && i < lane + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input op_t op, input logic [31:0] v);
    logic [31:0] w;
    int sz;
    sz = op_size(op);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = v[8*(i % sz) +: 8];
    return w;
  endfunction

  // per-cycle expectations derived from the transaction timeline
  always @(negedge clk) begin
    if (rstn && !quiet) begin
      if (txn_active) begin
        logic exp_req, exp_done;
        exp_req  = (k >= 1) && (k <= cur_R);
        exp_done = (k >= cur_R + 1) && (k <= cur_Le);
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        chk("done", 32'(done), 32'(exp_done));
        chk("reg_write_enabled", 32'(reg_write_enabled), 32'((k == cur_R + 1) && cur_wb));
        if (exp_req) begin
          chk("mem_we", 32'(mem_we), 32'(cur_st));
          chk("mem_addr", mem_addr, cur_addr_w);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(cur_wstrb));
          if (cur_st) chk("mem_wdata", mem_wdata, cur_wdata);
          if (cur_st && cur_has_lit) chk("mem_wdata_literal", mem_wdata, cur_lit);
        end
        if (exp_done) begin
          chk("misaligned", 32'(misaligned), 32'(cur_mis));
          chk("bus_error", 32'(bus_error), 32'(cur_to));
          chk("reg_write_dest", 32'(reg_write_dest), 32'(cur_rd));
          if (cur_chk_res) chk("result", result, cur_res);
          if (!cur_st && cur_has_lit) chk("result_literal", result, cur_lit);
        end else begin
          chk("misaligned_idle", 32'(misaligned), 32'd0);
          chk("bus_error_idle", 32'(bus_error), 32'd0);
        end
      end else begin
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_rwe", 32'(reg_write_enabled), 32'd0);
      end
    end
  end

  // d: REQ cycle in which mem_ready is high (0 = never, with a late ready
  // after timeout); leave: cycle index at which state stops being MEM.
  task automatic run_txn(input op_t op, input logic [31:0] addr, input logic [31:0] v,
                         input logic [31:0] rin, input logic [31:0] rd_word, input logic we,
                         input logic [4:0] rd, input int d, input int leave,
                         input logic has_lit, input logic [31:0] lit);
    logic is_mem;
    is_mem = (op_size(op) != 0);
    cur_st = op_store(op);
    cur_mis = is_mem && ((int'(addr[1:0]) % op_size(op)) != 0);
    cur_to = 1'b0;
    if (!is_mem || cur_mis) cur_R = 0;
    else if (d >= 1 && d <= T) cur_R = d;
    else begin cur_R = T; cur_to = 1'b1; end
    cur_Le = (leave > cur_R + 1) ? leave : cur_R + 1;
    cur_wb = we && !cur_st && !cur_mis && !cur_to;
    cur_addr_w = {addr[31:2], 2'b00};
    cur_wstrb = m_strb(op, addr);
    cur_wdata = m_wdata(op, v);
    cur_rd = rd;
    cur_chk_res = !is_mem || (!cur_st && !cur_mis && !cur_to);
    cur_res = is_mem ? m_load(op, addr, rd_word) : rin;
    cur_has_lit = has_lit;
    cur_lit = lit;

    k = 0;
    state = MEM;
    instr = to_instr(op);
    mem_target = addr;
    store_value = v;
    result_in = rin;
    reg_write_enabled_in = we;
    reg_write_dest_in = rd;
    mem_ready = 1'b0;
    mem_rdata = 32'hA5A5_5A5A;
    txn_active = 1'b1;
    while (k < cur_Le) begin
      @(posedge clk);
      #1;
      k++;
      state = (k < leave) ? MEM : 3'd4;
      instr = instructions'(8'($urandom));
      mem_target = $urandom;
      store_value = $urandom;
      result_in = $urandom;
      reg_write_enabled_in = ~we;
      reg_write_dest_in = 5'($urandom);
      mem_ready = (k == d) || (d == 0 && k == T + 1);
      mem_rdata = (k == d) ? rd_word : $urandom;
    end
    @(posedge clk);
    #1;
    txn_active = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    state = 3'd0;
    instr = '0;
    mem_target = '0;
    store_value = '0;
    result_in = '0;
    reg_write_enabled_in = 1'b0;
    reg_write_dest_in = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rwe", 32'(reg_write_enabled), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    run_txn(OP_ADD, 32'h0,     32'h0,         32'h1234,  32'h0,         1'b1, 5'd5, 0, 2, 1'b1, 32'h0000_1234);
    run_txn(OP_LB,  32'h103,   32'h0,         32'h0,     32'h80FF_FF7F, 1'b1, 5'd7, 1, 3, 1'b1, 32'hFFFF_FF80);
    run_txn(OP_LBU, 32'h103,   32'h0,         32'h0,     32'h80FF_FF7F, 1'b1, 5'd8, 1, 2, 1'b1, 32'h0000_0080);
    run_txn(OP_LH,  32'h102,   32'h0,         32'h0,     32'h80FF_FF7F, 1'b1, 5'd9, 1, 2, 1'b1, 32'hFFFF_80FF);
    run_txn(OP_LHU, 32'h102,   32'h0,         32'h0,     32'h80FF_FF7F, 1'b1, 5'd10, 2, 3, 1'b1, 32'h0000_80FF);
    run_txn(OP_LH,  32'h100,   32'h0,         32'h0,     32'h8000_7FFF, 1'b1, 5'd11, 1, 2, 1'b1, 32'h0000_7FFF);
    run_txn(OP_LW,  32'h10C,   32'h0,         32'h0,     32'h1234_5678, 1'b1, 5'd12, 2, 3, 1'b1, 32'h1234_5678);
    run_txn(OP_SH,  32'h206,   32'hDEAD_BEEF, 32'h0,     32'h0,         1'b1, 5'd3, 3, 4, 1'b1, 32'hBEEF_BEEF);
    run_txn(OP_SB,  32'h211,   32'h0000_00A7, 32'h0,     32'h0,         1'b1, 5'd4, 1, 2, 1'b1, 32'hA7A7_A7A7);
    run_txn(OP_SW,  32'h220,   32'hCAFE_F00D, 32'h0,     32'h0,         1'b0, 5'd6, 2, 3, 1'b1, 32'hCAFE_F00D);
    run_txn(OP_LW,  32'h101,   32'h0,         32'h0,     32'h0,         1'b1, 5'd13, 1, 2, 1'b0, 32'h0);
    run_txn(OP_LH,  32'h103,   32'h0,         32'h0,     32'h0,         1'b1, 5'd14, 1, 2, 1'b0, 32'h0);
    run_txn(OP_SH,  32'h105,   32'h1111_2222, 32'h0,     32'h0,         1'b0, 5'd15, 1, 3, 1'b0, 32'h0);
    run_txn(OP_LW,  32'h400,   32'h0,         32'h0,     32'h0,         1'b1, 5'd16, 0, 7, 1'b0, 32'h0);
    run_txn(OP_LB,  32'h101,   32'h0,         32'h0,     32'h0000_9C00, 1'b1, 5'd17, 2, 1, 1'b1, 32'hFFFF_FF9C);
    run_txn(OP_ADD, 32'h0,     32'h0,         32'h5555,  32'h0,         1'b1, 5'd0, 0, 1, 1'b1, 32'h0000_5555);
    run_txn(OP_ADD, 32'h0,     32'h0,         32'h7777,  32'h0,         1'b0, 5'd21, 0, 2, 1'b0, 32'h0);

    // reset while a request is outstanding
    quiet = 1'b1;
    instr = to_instr(OP_LW);
    mem_target = 32'h300;
    state = MEM;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_reset_mem_req", 32'(mem_req), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_dest", 32'(reg_write_dest), 32'd0);
    chk("async_rst_bus_error", 32'(bus_error), 32'd0);
    state = 3'd0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    quiet = 1'b0;
    run_txn(OP_LBU, 32'h3FE,   32'h0,         32'h0,     32'h00C3_0000, 1'b1, 5'd22, 1, 2, 1'b1, 32'h0000_00C3);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute stage's effective address, ALU result, destination register and decoded instruction flags.
- Performs load/store transactions on a req/ready data-memory bus, with byte-lane steering and load sign/zero extension.
- Produces the final writeback value, write enable and destination for the writeback stage.
- The core controller advances state past MEM only when done is high.

Parameters:
TIMEOUT_CYCLES, 1024, bus wait limit in cycles before bus_error; 0 disables the timeout.

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
state  input  3  core controller state; the block is active while state == MEM
instr  input  instructions  decoded flags; uses lb, lh, lw, lbu, lhu, sb, sh, sw
mem_target  input  32  effective byte address from execute
store_value  input  32  rs2 value to store
result_in  input  32  execute result, passed through for non-loads
reg_write_enabled_in  input  1  writeback request from execute
reg_write_dest_in  input  5  destination register from execute
mem_req  output  1  bus request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  word address: {mem_target[31:2], 2'b00}
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte write strobes; 0 on reads
mem_ready  input  1  bus completion; read data valid in the same cycle
mem_rdata  input  32  bus read data
result  output  32  writeback value
reg_write_enabled  output  1  one-cycle writeback strobe
reg_write_dest  output  5  writeback register
done  output  1  stage complete (level)
misaligned  output  1  alignment fault flag for the current access
bus_error  output  1  timeout fault flag for the current access

Behaviour:
- Reset (rstn low, asynchronous) forces:
  - FSM to IDLE;
  - all outputs to 0, including mem_req, which drops immediately;
  - the timeout counter to 0.
- FSM states: IDLE, REQ, DONE.
- IDLE, with state == MEM: capture all inputs into internal registers and classify the access.
  - load = lb|lh|lw|lbu|lhu; store = sb|sh|sw.
  - Misaligned when lw/sw with addr[1:0] != 0, or lh/lhu/sh with addr[0] != 0. Set misaligned=1, issue no bus access, go to DONE.
  - Neither load nor store: result = result_in, go to DONE. Latency 1 cycle from MEM entry to done.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1, and mem_addr/mem_we/mem_wdata/mem_wstrb stay stable until mem_ready is sampled high.
  - mem_ready high at a posedge completes the access: mem_req deasserts and the FSM goes to DONE.
  - mem_ready asserted in the first REQ cycle is legal. Minimum load/store latency is 2 cycles to done.
  - The timeout counter increments each REQ cycle. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): drop mem_req, set bus_error=1, go to DONE.
  - A late mem_ready after a timeout is ignored.
- DONE:
  - done=1; stay in DONE while state == MEM.
  - Go to IDLE when state != MEM; done, misaligned and bus_error clear on that transition.
- Store lane steering (lane = addr[1:0]):
  - sb: wdata = {4{v[7:0]}}, wstrb = 4'b0001 << lane.
  - sh: wdata = {2{v[15:0]}}, wstrb = 4'b0011 << lane.
  - sw: wdata = v, wstrb = 4'b1111.
- Load extraction:
  - byte = rdata[8*lane +: 8]; half = rdata[16*addr[1] +: 16].
  - lb/lh sign-extend to 32 bits; lbu/lhu zero-extend; lw takes the full word.
  - result is registered on the completing mem_ready edge.
- Writeback:
  - reg_write_enabled pulses exactly one cycle, the first DONE cycle.
  - It pulses only if reg_write_enabled_in=1, the instruction is not a store, and there is no fault.
  - Writes to x0 are passed through; the register file ignores them.
- Boundaries:
  - State leaving MEM while in REQ is a controller error. The block completes the bus handshake anyway (a request is never withdrawn except by timeout) and then returns through DONE to IDLE.
  - State returning to MEM in the cycle IDLE is entered starts a fresh access.
  - Captured inputs are used throughout, so input changes after capture are ignored.

Decomposition:
- def.sv holds the shared items:
  - MEM state constant;
  - lbu/lhu fields added to the instructions struct;
  - the mem FSM enum (IDLE/REQ/DONE).
- One natural sub-module: load_extend (combinational).
  - Inputs: rdata, addr[1:0], load flags.
  - Output: the 32-bit extended value.
- Store steering stays inline.

Test Plan:
- Pass-through: add with result_in=32'h1234, reg_write_enabled_in=1, rd=5, state=MEM → done after 1 cycle, result=32'h1234, one-cycle reg_write_enabled, reg_write_dest=5, mem_req never high.
- Loads: lb, addr 0x103, rdata 32'h80FF_FF7F, ready same cycle → result 32'hFFFF_FF80. lbu at the same address → 32'h0000_0080. lh at 0x102 → 32'hFFFF_80FF.
- Store with wait: sh at 0x206, v=32'hDEAD_BEEF, ready after 3 cycles → mem_addr 0x204, wdata 32'hBEEF_BEEF, wstrb 4'b1100 held stable 3 cycles; reg_write_enabled stays 0.
- Misaligned: lw at 0x101 → no mem_req, misaligned=1, done next cycle, reg_write_enabled=0.
- Timeout: TIMEOUT_CYCLES=4, load with mem_ready tied 0 → mem_req high 4 cycles then low, bus_error=1, done=1, no register write.
- Reset mid-REQ: rstn low while mem_req=1 → mem_req 0 without a clock edge, all outputs 0; after release with state=MEM, a new access starts cleanly.
